// File: rtl/adau_pkg.sv
// Shared definitions for the ADAU codec audio path: the default sample width,
// the stereo frame type and the I2S receive deserializer states.
package adau_pkg;

  localparam int ADAU_SAMPLE_W = 24;

  // Stereo frame as stored in the receive FIFO: {left, right}.
  typedef logic [2*ADAU_SAMPLE_W-1:0] adau_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry and holds
// its last value when the FIFO runs empty. Push and pop may share a cycle, even when full.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic             pop_eff;
  logic             push_eff;

  assign empty      = (level == '0);
  assign full       = (level == FULL_LEVEL);
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign pop_eff    = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_eff   = push & (~full | pop_eff);

  // NOTE: storage has no reset; the registered rdata hides stale entries, so
  // clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdata  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr_inc;

      case ({push_eff, pop_eff})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Keep the head register in step with the entry at rd_ptr after this edge.
      if (empty) begin
        if (push_eff) rdata <= wdata;
      end else if (pop_eff) begin
        if (level != ONE_LEVEL) rdata <= mem[rd_ptr_inc];
        else if (push_eff)      rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/adau_i2s_rx.sv
// I2S receiver for the ADAU ADC data pin: synchronizes bclk/lrclk/sdata into clk,
// deserializes stereo frames and queues them. Define ADAU_RX_DROP_CNT_EN for drop_cnt.
module adau_i2s_rx
  import adau_pkg::*;
#(
  parameter int SAMPLE_W   = ADAU_SAMPLE_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          bclk,
  input  logic                          lrclk,
  input  logic                          sdata,
  input  logic                          enable,
  output logic [2*SAMPLE_W-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          overflow,
  input  logic                          overflow_clr
`ifdef ADAU_RX_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam logic [4:0] LAST_BIT = 5'(SAMPLE_W);
  localparam logic [4:0] CNT_MAX  = 5'd31;

  logic [1:0]          bclk_sync;
  logic [1:0]          lrclk_sync;
  logic [1:0]          sdata_sync;
  logic                bclk_d;
  logic                bclk_rise;
  logic                lr;
  logic                sd;

  logic                lrclk_prev;
  logic [4:0]          bit_cnt;
  logic [4:0]          bit_cnt_inc;
  logic                lr_edge;
  logic                bit_tick;
  logic                slot_full;
  logic                word_done;
  logic [SAMPLE_W-2:0] shift_reg;
  logic [SAMPLE_W-1:0] word;

  rx_state_e           state;
  rx_state_e           state_next;
  logic                frame_ok;
  logic                frame_ok_next;
  logic                latch_left;
  logic                push_next;
  logic                push_q;
  logic [SAMPLE_W-1:0] left_word;
  logic [2*SAMPLE_W-1:0] frame_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      bclk_d     <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[0], bclk};
      lrclk_sync <= {lrclk_sync[0], lrclk};
      sdata_sync <= {sdata_sync[0], sdata};
      bclk_d     <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_d;
  assign lr        = lrclk_sync[1];
  assign sd        = sdata_sync[1];

  // The bit right after an lrclk change is the I2S delay slot and carries no data.
  assign lr_edge     = bclk_rise & (lr != lrclk_prev);
  assign bit_tick    = bclk_rise & (lr == lrclk_prev);
  assign bit_cnt_inc = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 5'd1;
  assign slot_full   = (bit_cnt >= LAST_BIT);
  assign word_done   = bit_tick & (bit_cnt_inc == LAST_BIT);
  assign word        = {shift_reg, sd};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lrclk_prev <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else if (bclk_rise) begin
      lrclk_prev <= lr;
      if (lr_edge) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt_inc;
        if (bit_cnt_inc <= LAST_BIT) shift_reg <= word[SAMPLE_W-2:0];
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    frame_ok_next = frame_ok;
    latch_left    = 1'b0;
    push_next     = 1'b0;
    if (!enable) begin
      state_next    = IDLE;
      frame_ok_next = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lr_edge && !lr) state_next = LEFT;
        end
        LEFT: begin
          if (lr_edge) begin
            state_next = lr ? RIGHT : LEFT;
            if (!slot_full) frame_ok_next = 1'b0;
          end else if (word_done) begin
            latch_left    = 1'b1;
            frame_ok_next = 1'b1;
          end
        end
        RIGHT: begin
          if (lr_edge) begin
            state_next = lr ? RIGHT : LEFT;
            if (!slot_full) frame_ok_next = 1'b0;
          end else if (word_done) begin
            push_next     = frame_ok;
            frame_ok_next = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      frame_ok  <= 1'b0;
      push_q    <= 1'b0;
      left_word <= '0;
      frame_q   <= '0;
    end else begin
      state    <= state_next;
      frame_ok <= frame_ok_next;
      push_q   <= push_next;
      if (latch_left) left_word <= word;
      if (push_next)  frame_q   <= {left_word, word};
    end
  end

  assign rx_valid = ~fifo_empty;
  assign pop      = rx_valid & rx_ready;
  assign drop     = push_q & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_q),
    .wdata  (frame_q),
    .pop    (pop),
    .rdata  (rx_data),
    .level  (rx_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!resetn)           overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef ADAU_RX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn)                        drop_cnt <= '0;
    else if (overflow_clr)              drop_cnt <= {15'd0, drop};
    else if (drop && drop_cnt != '1)    drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adau_i2s_rx.sv
// Self-checking bench for adau_i2s_rx: directed frame table, FIFO/overflow/reset
// sequences and randomized frames scored against a frame-level queue model.
`timescale 1ns/1ps
module tb_adau_i2s_rx;
  import adau_pkg::*;

  localparam int SW    = ADAU_SAMPLE_W;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic bclk = 1'b0;
  logic lrclk = 1'b0;
  logic sdata = 1'b0;
  logic enable = 1'b0;
  logic rx_ready = 1'b0;
  logic overflow_clr = 1'b0;
  logic [2*SW-1:0]          rx_data;
  logic                     rx_valid;
  logic [$clog2(DEPTH):0]   rx_level;
  logic                     overflow;
`ifdef ADAU_RX_DROP_CNT_EN
  logic [15:0]              drop_cnt;
`endif

  adau_i2s_rx #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .enable       (enable),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_level     (rx_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef ADAU_RX_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model, kept at frame granularity.
  adau_frame_t exp_q[$];
  bit          armed = 1'b0;
  bit          lr_prev_seen = 1'b0;
  bit          ovf_m = 1'b0;
  int          drops_m = 0;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    int            lbits;
    int            mode;
    int            en_off;
    int            exp_level;
    logic [2*SW-1:0] exp_head;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input adau_frame_t f);
    if (exp_q.size() == DEPTH) begin
      ovf_m = 1'b1;
      if (drops_m < 65535) drops_m++;
    end else begin
      exp_q.push_back(f);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    armed = 1'b0;
    lr_prev_seen = 1'b0;
    ovf_m = 1'b0;
    drops_m = 0;
  endtask

  // One bclk period (8 clk). mode acts in the clk cycle that ends 4 edges after the rise.
  task automatic bclk_cycle(input logic lr, input logic sd, input int mode);
    bclk = 1'b0;
    lrclk = lr;
    sdata = sd;
    repeat (4) tick();
    bclk = 1'b1;
    repeat (3) tick();
    case (mode)
      1: check("latency_before", 64'(rx_valid), 64'd0);
      2: rx_ready = 1'b1;
      3: overflow_clr = 1'b1;
      default: ;
    endcase
    tick();
    case (mode)
      1: check("latency_at4", 64'(rx_valid), 64'd1);
      2: rx_ready = 1'b0;
      3: overflow_clr = 1'b0;
      default: ;
    endcase
  endtask

  task automatic send_slot(input logic lr, input logic [SW-1:0] w, input int nbits,
                           input int lsb_mode, input int en_off_at);
    int   n;
    logic sd;
    bclk_cycle(lr, 1'($urandom_range(0, 1)), 0);
    n = (nbits < SW) ? nbits : 31;
    for (int i = 0; i < n; i++) begin
      sd = (i < SW) ? w[SW-1-i] : 1'($urandom_range(0, 1));
      if (i == en_off_at) enable = 1'b0;
      bclk_cycle(lr, sd, (i == SW-1) ? lsb_mode : 0);
      if (i == en_off_at) enable = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int lbits,
                            input int mode, input int en_off_at);
    bit push;
    if (lr_prev_seen && enable) armed = 1'b1;
    push = armed && (lbits == SW) && (en_off_at < 0);
    if (en_off_at >= 0) armed = 1'b0;
    send_slot(1'b0, l, lbits, 0, en_off_at);
    send_slot(1'b1, r, SW, mode, -1);
    lr_prev_seen = 1'b1;
    if (mode == 2 && exp_q.size() != 0) void'(exp_q.pop_front());
    if (mode == 3) begin
      ovf_m = 1'b0;
      drops_m = 0;
    end
    if (push) model_push({l, r});
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, 64'(rx_level), 64'(exp_q.size()));
    check({tag, "_valid"}, 64'(rx_valid), 64'(exp_q.size() != 0));
    check({tag, "_overflow"}, 64'(overflow), 64'(ovf_m));
`ifdef ADAU_RX_DROP_CNT_EN
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(drops_m));
`endif
    if (exp_q.size() != 0) check({tag, "_head"}, 64'(rx_data), 64'(exp_q[0]));
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_pop_data"}, 64'(rx_data), 64'(exp_q[0]));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    void'(exp_q.pop_front());
    check({tag, "_pop_level"}, 64'(rx_level), 64'(exp_q.size()));
  endtask

  task automatic drain(input string tag);
    adau_frame_t last;
    last = '0;
    while (exp_q.size() != 0) begin
      last = exp_q[0];
      pop_one(tag);
    end
    tick();
    check({tag, "_empty_valid"}, 64'(rx_valid), 64'd0);
    check({tag, "_empty_hold"}, 64'(rx_data), 64'(last));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{24'hABCDEF, 24'h123456, SW, 0, -1, 0, 48'h0};
    vecs[1] = '{24'hABCDEF, 24'h123456, SW, 1, -1, 1, 48'hABCDEF123456};
    vecs[2] = '{24'h111111, 24'h222222, 12, 0, -1, 1, 48'hABCDEF123456};
    vecs[3] = '{24'h333333, 24'h444444, SW, 0, -1, 2, 48'hABCDEF123456};
    vecs[4] = '{24'h555555, 24'h666666, SW, 0,  5, 2, 48'hABCDEF123456};
    vecs[5] = '{24'h777777, 24'h888888, SW, 0, -1, 3, 48'hABCDEF123456};

    repeat (3) tick();
    check("reset_valid", 64'(rx_valid), 64'd0);
    check("reset_data", 64'(rx_data), 64'd0);
    check("reset_level", 64'(rx_level), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
`ifdef ADAU_RX_DROP_CNT_EN
    check("reset_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    resetn = 1'b1;
    enable = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].l, vecs[v].r, vecs[v].lbits, vecs[v].mode, vecs[v].en_off);
      check($sformatf("vec%0d_level", v), 64'(rx_level), 64'(vecs[v].exp_level));
      check($sformatf("vec%0d_head", v), 64'(rx_data), 64'(vecs[v].exp_head));
      check_state($sformatf("vec%0d", v));
    end
    drain("table");

    // Ten frames into an eight-deep FIFO with nobody reading.
    for (int f = 1; f <= 10; f++)
      send_frame(SW'($urandom), SW'($urandom), SW, 0, -1);
    check("ovf10_level", 64'(rx_level), 64'd8);
    check("ovf10_overflow", 64'(overflow), 64'd1);
`ifdef ADAU_RX_DROP_CNT_EN
    check("ovf10_drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    check_state("ovf10");

    // Drop and clear in the same cycle: the drop wins.
    send_frame(SW'($urandom), SW'($urandom), SW, 3, -1);
    check("dropclr_overflow", 64'(overflow), 64'd1);
`ifdef ADAU_RX_DROP_CNT_EN
    check("dropclr_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    check_state("dropclr");

    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    ovf_m = 1'b0;
    drops_m = 0;
    check("clr_overflow", 64'(overflow), 64'd0);
    check_state("clr");

    // Full FIFO, pop coincides with the push: nothing dropped.
    check("fullpop_head", 64'(rx_data), 64'(exp_q[0]));
    send_frame(SW'($urandom), SW'($urandom), SW, 2, -1);
    check("fullpop_level", 64'(rx_level), 64'd8);
    check("fullpop_overflow", 64'(overflow), 64'd0);
    check_state("fullpop");
    drain("fullpop");

    // Reset mid right word with three frames queued.
    for (int f = 0; f < 3; f++)
      send_frame(SW'($urandom), SW'($urandom), SW, 0, -1);
    check("prereset_level", 64'(rx_level), 64'd3);
    send_slot(1'b0, SW'($urandom), SW, 0, -1);
    for (int i = 0; i < 7; i++) bclk_cycle(1'b1, 1'($urandom_range(0, 1)), 0);
    bclk = 1'b0;
    repeat (2) tick();
    resetn = 1'b0;
    tick();
    check("midreset_level", 64'(rx_level), 64'd0);
    check("midreset_valid", 64'(rx_valid), 64'd0);
    check("midreset_overflow", 64'(overflow), 64'd0);
`ifdef ADAU_RX_DROP_CNT_EN
    check("midreset_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    resetn = 1'b1;
    model_reset();
    tick();

    // Random frames, occasional short left slots, random reads in between.
    for (int k = 0; k < 14; k++) begin
      int lbits;
      int npop;
      lbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, SW-1)) : SW;
      send_frame(SW'($urandom), SW'($urandom), lbits, 0, -1);
      check_state($sformatf("rand%0d", k));
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++)
        if (exp_q.size() != 0) pop_one($sformatf("rand%0d", k));
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
